// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - bundled data, request and status signals of sync_fifo_prog
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output data_in, wr_en, rd_en, af_thresh, ae_thresh,
        input  data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en, af_thresh, ae_thresh,
        output data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO, any depth, programmable almost flags, optional FWFT
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit FWFT       = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  full;
    logic                  wr_acc;
    logic                  rd_acc;

    assign empty  = (count == '0);
    assign full   = (count == CNT_MAX);
    assign rd_acc = bus.rd_en && !empty;
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= bus.wr_en && !wr_acc;
            underflow <= bus.rd_en && !rd_acc;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (bus.af_thresh != '0) && (count >= bus.af_thresh);
    assign bus.almostempty = (count <= bus.ae_thresh);
    assign bus.wr_ack      = wr_ack;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - three FIFO configurations driven in lockstep against a queue model
module tb_sync_fifo_prog;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_in;
    int          af_thr [3];
    int          ae_thr [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    // dut 0: depth 8 registered read, dut 1: depth 5 registered read, dut 2: depth 8 FWFT
    int          depth [3] = '{8, 5, 8};
    bit          fwft  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mq    [3][$];
    logic [15:0] m_dout [3];
    bit          m_ack [3];
    bit          m_ovf [3];
    bit          m_udf [3];

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if0 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if1 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if2 ();

    assign if0.data_in = data_in;  assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;
    assign if1.data_in = data_in;  assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;
    assign if2.data_in = data_in;  assign if2.wr_en = wr_en;  assign if2.rd_en = rd_en;
    assign if0.af_thresh = 4'(af_thr[0]);  assign if0.ae_thresh = 4'(ae_thr[0]);
    assign if1.af_thresh = 3'(af_thr[1]);  assign if1.ae_thresh = 3'(ae_thr[1]);
    assign if2.af_thresh = 4'(af_thr[2]);  assign if2.ae_thresh = 4'(ae_thr[2]);

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int k);
        int  n;
        bit  rd_ok;
        bit  wr_ok;
        if (!rst_n) begin
            mq[k].delete();
            m_dout[k] = '0;
            m_ack[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
            m_udf[k]  = 1'b0;
            return;
        end
        n     = mq[k].size();
        rd_ok = rd_en && (n > 0);
        wr_ok = wr_en && ((n < depth[k]) || rd_ok);
        if (rd_ok) m_dout[k] = mq[k].pop_front();
        if (wr_ok) mq[k].push_back(data_in);
        m_ack[k] = wr_ok;
        m_ovf[k] = wr_en && !wr_ok;
        m_udf[k] = rd_en && !rd_ok;
    endtask

    task automatic check_dut(input int k);
        logic [31:0] o_cnt;
        logic [15:0] o_dout;
        logic [3:0]  o_flags;
        logic [2:0]  o_stat;
        logic [15:0] e_dout;
        logic [3:0]  e_flags;
        int          n;
        case (k)
            0: begin
                o_cnt = 32'(if0.count); o_dout = if0.data_out;
                o_flags = {if0.full, if0.empty, if0.almostfull, if0.almostempty};
                o_stat  = {if0.wr_ack, if0.overflow, if0.underflow};
            end
            1: begin
                o_cnt = 32'(if1.count); o_dout = if1.data_out;
                o_flags = {if1.full, if1.empty, if1.almostfull, if1.almostempty};
                o_stat  = {if1.wr_ack, if1.overflow, if1.underflow};
            end
            default: begin
                o_cnt = 32'(if2.count); o_dout = if2.data_out;
                o_flags = {if2.full, if2.empty, if2.almostfull, if2.almostempty};
                o_stat  = {if2.wr_ack, if2.overflow, if2.underflow};
            end
        endcase
        n = mq[k].size();
        e_flags = {n == depth[k], n == 0, (af_thr[k] != 0) && (n >= af_thr[k]), n <= ae_thr[k]};
        if (fwft[k]) e_dout = (n > 0) ? mq[k][0] : 16'h0;
        else         e_dout = m_dout[k];
        check($sformatf("d%0d_count", k), o_cnt, 32'(n));
        check($sformatf("d%0d_data_out", k), 32'(o_dout), 32'(e_dout));
        check($sformatf("d%0d_flags(full,empty,af,ae)", k), 32'(o_flags), 32'(e_flags));
        check($sformatf("d%0d_stat(ack,ovf,udf)", k), 32'(o_stat), 32'({m_ack[k], m_ovf[k], m_udf[k]}));
    endtask

    task automatic step(input bit w, input bit r, input logic [15:0] d, input bit rn);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        rst_n   = rn;
        for (int k = 0; k < 3; k++) model_update(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    initial begin
        af_thr = '{6, 4, 6};
        ae_thr = '{1, 1, 1};
        wr_en = 1'b0; rd_en = 1'b0; data_in = '0; rst_n = 1'b0;
        #1;

        step(0, 0, 16'h0, 0);
        check("reset_empty", 32'(if0.empty), 32'd1);
        check("reset_almostempty", 32'(if0.almostempty), 32'd1);

        // reset in the middle of a fill
        for (int i = 0; i < 3; i++) step(1, 0, 16'(16'h100 + i), 1);
        step(0, 0, 16'h0, 0);
        check("midfill_rst_count", 32'(if0.count), 32'd0);
        check("midfill_rst_dout", 32'(if0.data_out), 32'd0);
        step(0, 1, 16'h0, 1);
        check("midfill_rst_underflow", 32'(if0.underflow), 32'd1);

        // fill to full and beyond
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 16'(16'h200 + i), 1);
            if (i == 4) check("fill_af_at5", 32'(if0.almostfull), 32'd0);
            if (i == 5) check("fill_af_at6", 32'(if0.almostfull), 32'd1);
            if (i == 7) check("fill_full_at8", 32'(if0.full), 32'd1);
        end
        check("fill_overflow", 32'(if0.overflow), 32'd1);
        check("fill_ovf_noack", 32'(if0.wr_ack), 32'd0);
        check("fill_count", 32'(if0.count), 32'd8);

        step(1, 1, 16'h0999, 1);
        check("full_rw_ack", 32'(if0.wr_ack), 32'd1);
        check("full_rw_dout", 32'(if0.data_out), 32'h200);

        // simultaneous request on an empty FIFO
        step(0, 0, 16'h0, 0);
        step(1, 1, 16'hA5A5, 1);
        check("empty_rw_underflow", 32'(if0.underflow), 32'd1);
        check("empty_rw_count", 32'(if0.count), 32'd1);
        step(0, 1, 16'h0, 1);
        check("empty_rw_readback", 32'(if0.data_out), 32'hA5A5);

        // depth-5 wrap with overlapping traffic
        step(0, 0, 16'h0, 0);
        step(1, 0, 16'd1, 1);
        for (int i = 2; i <= 12; i++) step(1, 1, 16'(i), 1);
        step(0, 1, 16'h0, 1);
        check("wrap_last_word", 32'(if1.data_out), 32'd12);

        // first-word-fall-through presentation
        step(0, 0, 16'h0, 0);
        step(1, 0, 16'h0011, 1);
        step(1, 0, 16'h0022, 1);
        check("fwft_head", 32'(if2.data_out), 32'h11);
        step(0, 1, 16'h0, 1);
        check("fwft_second", 32'(if2.data_out), 32'h22);
        check("fwft_ae", 32'(if2.almostempty), 32'd1);
        step(0, 1, 16'h0, 1);
        check("fwft_drained_dout", 32'(if2.data_out), 32'h0);

        // randomized traffic with changing thresholds and occasional reset
        for (int c = 0; c < 1500; c++) begin
            if (c % 60 == 0) begin
                af_thr[0] = $urandom_range(0, 8); ae_thr[0] = $urandom_range(0, 8);
                af_thr[1] = $urandom_range(0, 5); ae_thr[1] = $urandom_range(0, 5);
                af_thr[2] = $urandom_range(0, 8); ae_thr[2] = $urandom_range(0, 8);
            end
            step(($urandom_range(0, 99) < ((c / 200) % 2 ? 35 : 65)),
                 ($urandom_range(0, 99) < ((c / 200) % 2 ? 65 : 35)),
                 16'($urandom), ($urandom_range(0, 99) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
